// File: rtl/sort_engine_dispatcher.sv
// Round-robin packet dispatcher over ENGINE_CNT sort engines; an order FIFO of
// engine indices makes results leave in the same order packets arrived.
module sort_engine_dispatcher #(
    parameter int DWIDTH      = 32,
    parameter int ENGINE_CNT  = 2,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DWIDTH-1:0]              data_i,
    input  logic                           sop_i,
    input  logic                           eop_i,
    input  logic                           val_i,
    output logic                           ready_o,
    output logic [DWIDTH-1:0]              eng_data_o,
    output logic                           eng_sop_o,
    output logic                           eng_eop_o,
    output logic [ENGINE_CNT-1:0]          eng_val_o,
    input  logic [ENGINE_CNT-1:0]          eng_ready_i,
    input  logic [ENGINE_CNT*DWIDTH-1:0]   eng_data_i,
    input  logic [ENGINE_CNT-1:0]          eng_sop_i,
    input  logic [ENGINE_CNT-1:0]          eng_eop_i,
    input  logic [ENGINE_CNT-1:0]          eng_val_i,
    output logic [ENGINE_CNT-1:0]          eng_ready_o,
    output logic [DWIDTH-1:0]              data_o,
    output logic                           sop_o,
    output logic                           eop_o,
    output logic                           val_o,
    input  logic                           ready_i,
    output logic [$clog2(ORDER_DEPTH):0]   order_cnt_o,
    output logic                           err_o
);

    localparam int SW = $clog2(ENGINE_CNT);
    localparam int AW = $clog2(ORDER_DEPTH);

    typedef enum logic {IDLE, PKT} state_t;

    state_t        state;
    logic [SW-1:0] in_sel;
    logic [SW-1:0] next_sel;
    logic [SW-1:0] out_sel;
    logic [SW-1:0] order_mem [ORDER_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          in_xfer;
    logic          push;
    logic          pop;
    logic          stray;

    assign fifo_full   = (count == (AW+1)'(ORDER_DEPTH));
    assign fifo_empty  = (count == '0);
    assign order_cnt_o = count;

    assign eng_data_o = data_i;
    assign eng_sop_o  = sop_i;
    assign eng_eop_o  = eop_i;

    assign next_sel = (in_sel == SW'(ENGINE_CNT - 1)) ? '0 : in_sel + 1'b1;

    // Full gates only a new sop; beats inside an accepted packet never stall on it.
    always_comb begin
        ready_o   = 1'b0;
        eng_val_o = '0;
        case (state)
            IDLE: begin
                if (sop_i) begin
                    ready_o           = eng_ready_i[in_sel] & ~fifo_full;
                    eng_val_o[in_sel] = val_i & ~fifo_full;
                end else begin
                    ready_o = 1'b1;
                end
            end
            PKT: begin
                ready_o           = eng_ready_i[in_sel];
                eng_val_o[in_sel] = val_i;
            end
            default: ;
        endcase
    end

    assign in_xfer = val_i & ready_o;
    assign push    = in_xfer & (state == IDLE) & sop_i;
    assign stray   = in_xfer & (state == IDLE) & ~sop_i;

    assign out_sel = order_mem[rd_ptr];

    always_comb begin
        data_o      = '0;
        sop_o       = 1'b0;
        eop_o       = 1'b0;
        val_o       = 1'b0;
        eng_ready_o = '0;
        for (int unsigned k = 0; k < ENGINE_CNT; k++) begin
            if (!fifo_empty && out_sel == SW'(k)) begin
                data_o         = eng_data_i[k*DWIDTH +: DWIDTH];
                sop_o          = eng_sop_i[k];
                eop_o          = eng_eop_i[k];
                val_o          = eng_val_i[k];
                eng_ready_o[k] = ready_i;
            end
        end
    end

    assign pop = val_o & ready_i & eop_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            order_mem[wr_ptr] <= in_sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            in_sel <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            err_o <= stray;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (push) begin
                        if (eop_i) in_sel <= next_sel;
                        else       state  <= PKT;
                    end
                end
                PKT: begin
                    if (in_xfer && eop_i) begin
                        in_sel <= next_sel;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_engine_dispatcher.sv
// Directed bench for sort_engine_dispatcher; engines are driven directly by the bench.
module tb_sort_engine_dispatcher;

    localparam int DW = 32;
    localparam int EC = 2;
    localparam int OD = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [DW-1:0]     data_i;
    logic              sop_i, eop_i, val_i;
    logic              ready_o;
    logic [DW-1:0]     eng_data_o;
    logic              eng_sop_o, eng_eop_o;
    logic [EC-1:0]     eng_val_o;
    logic [EC-1:0]     eng_ready_i;
    logic [EC*DW-1:0]  eng_data_i;
    logic [EC-1:0]     eng_sop_i, eng_eop_i, eng_val_i;
    logic [EC-1:0]     eng_ready_o;
    logic [DW-1:0]     data_o;
    logic              sop_o, eop_o, val_o;
    logic              ready_i;
    logic [2:0]        order_cnt_o;
    logic              err_o;

    int n_chk  = 0;
    int n_pass = 0;

    sort_engine_dispatcher #(
        .DWIDTH      (DW),
        .ENGINE_CNT  (EC),
        .ORDER_DEPTH (OD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .sop_i       (sop_i),
        .eop_i       (eop_i),
        .val_i       (val_i),
        .ready_o     (ready_o),
        .eng_data_o  (eng_data_o),
        .eng_sop_o   (eng_sop_o),
        .eng_eop_o   (eng_eop_o),
        .eng_val_o   (eng_val_o),
        .eng_ready_i (eng_ready_i),
        .eng_data_i  (eng_data_i),
        .eng_sop_i   (eng_sop_i),
        .eng_eop_i   (eng_eop_i),
        .eng_val_i   (eng_val_i),
        .eng_ready_o (eng_ready_o),
        .data_o      (data_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .val_o       (val_o),
        .ready_i     (ready_i),
        .order_cnt_o (order_cnt_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offer an n-beat packet; every beat must be accepted by the expected engine.
    task automatic send_pkt(input int n, input logic [DW-1:0] base, input logic [EC-1:0] exp_val);
        for (int i = 0; i < n; i++) begin
            val_i  = 1'b1;
            sop_i  = (i == 0);
            eop_i  = (i == n - 1);
            data_i = base + DW'(i);
            #1;
            chk("eng_val_o", eng_val_o, exp_val);
            chk("ready_o", ready_o, 1'b1);
            chk("eng_data_o", eng_data_o, base + DW'(i));
            chk("eng_eop_o", eng_eop_o, (i == n - 1));
            step();
        end
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
    endtask

    // All engines present valid results; only engine eng may reach the output.
    task automatic collect(input int eng, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            eng_val_i = '1;
            for (int k = 0; k < EC; k++)
                eng_data_i[k*DW +: DW] = (k == eng) ? base + DW'(i) : 32'hBAD0_0000 + DW'(k);
            eng_sop_i = (i == 0)     ? EC'(1) << eng : '0;
            eng_eop_i = (i == n - 1) ? EC'(1) << eng : '0;
            #1;
            chk("val_o", val_o, 1'b1);
            chk("data_o", data_o, base + DW'(i));
            chk("sop_o", sop_o, (i == 0));
            chk("eop_o", eop_o, (i == n - 1));
            chk("eng_ready_o", eng_ready_o, EC'(1) << eng);
            step();
        end
        eng_val_i = '0;
        eng_sop_i = '0;
        eng_eop_i = '0;
    endtask

    initial begin
        rst_i       = 1'b1;
        data_i      = '0;
        sop_i       = 1'b0;
        eop_i       = 1'b0;
        val_i       = 1'b0;
        eng_ready_i = '1;
        eng_data_i  = '0;
        eng_sop_i   = '0;
        eng_eop_i   = '0;
        eng_val_i   = '1;
        ready_i     = 1'b1;
        repeat (2) step();

        // reset state: empty FIFO hides engine valids
        chk("rst val_o", val_o, 1'b0);
        chk("rst eng_ready_o", eng_ready_o, 2'b00);
        chk("rst order_cnt", order_cnt_o, 3'd0);
        chk("rst err_o", err_o, 1'b0);
        chk("rst eng_val_o", eng_val_o, 2'b00);
        rst_i     = 1'b0;
        eng_val_i = '0;
        step();

        // four 3-word packets round-robin 0,1,0,1
        send_pkt(3, 32'h100, 2'b01);
        chk("cnt after p1", order_cnt_o, 3'd1);
        send_pkt(3, 32'h110, 2'b10);
        send_pkt(3, 32'h120, 2'b01);
        send_pkt(3, 32'h130, 2'b10);
        chk("cnt after p4", order_cnt_o, 3'd4);

        // engine 1 ready first: held until engine 0 delivers
        eng_val_i = 2'b10;
        eng_sop_i = 2'b10;
        eng_data_i[DW +: DW] = 32'h110;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i % 5 == 0) begin
                chk("ooo val_o", val_o, 1'b0);
                chk("ooo eng_ready_o", eng_ready_o, 2'b01);
            end
            step();
        end
        chk("ooo cnt", order_cnt_o, 3'd4);
        collect(0, 3, 32'h100);
        collect(1, 3, 32'h110);
        collect(0, 3, 32'h120);
        collect(1, 3, 32'h130);
        #1;
        chk("drain cnt", order_cnt_o, 3'd0);

        // order FIFO full with downstream stalled
        ready_i = 1'b0;
        send_pkt(2, 32'h300, 2'b01);
        send_pkt(2, 32'h310, 2'b10);
        send_pkt(2, 32'h320, 2'b01);
        send_pkt(2, 32'h330, 2'b10);
        chk("full cnt", order_cnt_o, 3'd4);
        val_i  = 1'b1;
        sop_i  = 1'b1;
        eop_i  = 1'b0;
        data_i = 32'h340;
        #1;
        chk("full ready_o", ready_o, 1'b0);
        chk("full eng_val_o", eng_val_o, 2'b00);
        step();
        ready_i   = 1'b1;
        eng_val_i = 2'b01;
        eng_sop_i = 2'b01;
        eng_eop_i = 2'b01;
        eng_data_i[0 +: DW] = 32'h300;
        #1;
        chk("pop val_o", val_o, 1'b1);
        chk("pop data_o", data_o, 32'h300);
        chk("pop-cycle ready_o", ready_o, 1'b0);
        step();
        eng_val_i = '0;
        eng_sop_i = '0;
        eng_eop_i = '0;
        #1;
        chk("after pop cnt", order_cnt_o, 3'd3);
        chk("after pop ready_o", ready_o, 1'b1);
        chk("after pop eng_val_o", eng_val_o, 2'b01);
        step();
        sop_i  = 1'b0;
        eop_i  = 1'b1;
        data_i = 32'h341;
        #1;
        chk("p5 beat2 eng_val_o", eng_val_o, 2'b01);
        step();
        val_i = 1'b0;
        eop_i = 1'b0;
        #1;
        chk("p5 cnt", order_cnt_o, 3'd4);
        collect(1, 1, 32'h310);
        collect(0, 1, 32'h320);
        collect(1, 1, 32'h330);
        collect(0, 1, 32'h340);
        #1;
        chk("drain2 cnt", order_cnt_o, 3'd0);

        // stray beat in IDLE
        val_i  = 1'b1;
        data_i = 32'hEE;
        #1;
        chk("stray ready_o", ready_o, 1'b1);
        chk("stray eng_val_o", eng_val_o, 2'b00);
        chk("stray err_o pre", err_o, 1'b0);
        step();
        val_i = 1'b0;
        #1;
        chk("stray err_o", err_o, 1'b1);
        chk("stray cnt", order_cnt_o, 3'd0);
        step();
        chk("stray err_o clr", err_o, 1'b0);
        send_pkt(2, 32'h400, 2'b10);

        // single-beat packets and in_sel wrap
        send_pkt(1, 32'h5, 2'b01);
        send_pkt(2, 32'h500, 2'b10);
        send_pkt(1, 32'h6, 2'b01);
        chk("single cnt", order_cnt_o, 3'd4);

        // reset mid-packet
        collect(1, 2, 32'h400);
        val_i  = 1'b1;
        sop_i  = 1'b1;
        data_i = 32'h600;
        #1;
        chk("pre-rst eng_val_o", eng_val_o, 2'b10);
        step();
        sop_i     = 1'b0;
        data_i    = 32'h601;
        eng_val_i = '1;
        #1;
        chk("pre-rst val_o", val_o, 1'b1);
        chk("pkt eng_val_o", eng_val_o, 2'b10);
        rst_i = 1'b1;
        val_i = 1'b0;
        #1;
        chk("mid-rst val_o", val_o, 1'b0);
        chk("mid-rst cnt", order_cnt_o, 3'd0);
        chk("mid-rst eng_ready_o", eng_ready_o, 2'b00);
        step();
        rst_i     = 1'b0;
        eng_val_i = '0;
        val_i     = 1'b1;
        sop_i     = 1'b1;
        eop_i     = 1'b1;
        data_i    = 32'h700;
        #1;
        chk("post-rst eng_val_o", eng_val_o, 2'b01);
        step();
        val_i = 1'b0;
        sop_i = 1'b0;
        eop_i = 1'b0;
        #1;
        chk("post-rst cnt", order_cnt_o, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sort_engine_dispatcher.md
Name: sort_engine_dispatcher

Overview:
Packet scheduler that shares ENGINE_CNT parallel sort engines between one input stream and one output stream. Whole packets (sop..eop) are dispatched to engines in strict round-robin order. Each dispatched engine index is recorded in an order FIFO, and results are collected from engines in that same order, so output packet order equals input packet order. It sits between the top-level registered stream boundary and the engine array, replacing the fixed engine wiring.

Parameters:
DWIDTH, 32, data word width
ENGINE_CNT, 2, number of sort engines (2..8)
ORDER_DEPTH, 4, order FIFO depth in packets (power of 2, >= 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
data_i  in  DWIDTH  input stream data
sop_i  in  1  input start of packet
eop_i  in  1  input end of packet
val_i  in  1  input beat valid
ready_o  out  1  input beat accept
eng_data_o  out  DWIDTH  data broadcast to all engines
eng_sop_o  out  1  sop broadcast
eng_eop_o  out  1  eop broadcast
eng_val_o  out  ENGINE_CNT  per-engine valid, one-hot or zero
eng_ready_i  in  ENGINE_CNT  per-engine input ready
eng_data_i  in  ENGINE_CNT*DWIDTH  engine result data, engine k at bits [k*DWIDTH +: DWIDTH]
eng_sop_i  in  ENGINE_CNT  engine result sop
eng_eop_i  in  ENGINE_CNT  engine result eop
eng_val_i  in  ENGINE_CNT  engine result valid
eng_ready_o  out  ENGINE_CNT  per-engine result ready, one-hot or zero
data_o  out  DWIDTH  output stream data
sop_o  out  1  output sop
eop_o  out  1  output eop
val_o  out  1  output valid
ready_i  in  1  downstream ready
order_cnt_o  out  $clog2(ORDER_DEPTH)+1  packets dispatched but not fully collected
err_o  out  1  one-cycle pulse on dropped stray beat

Behaviour:
- Beat transfer = val & ready on the same side, same cycle. All data paths are combinational muxes (0 latency). State is held in registers only.
- Reset (async, active-high): in_sel=0, input FSM=IDLE, FIFO empty, order_cnt_o=0, err_o=0. Consequently val_o=0, eng_val_o=0, eng_ready_o=0. A reset mid-packet abandons the packet; the engines are reset by the same rst_i.
- Input FSM states: IDLE (between packets), PKT (inside packet to engine in_sel).
- IDLE, sop_i=1: ready_o = eng_ready_i[in_sel] & ~fifo_full. eng_val_o[in_sel] = val_i & ~fifo_full. On transfer, push in_sel into the FIFO. If eop_i=0, go to PKT. If eop_i=1 (single-beat packet), stay in IDLE and advance in_sel.
- IDLE, sop_i=0 with val_i=1: stray beat. ready_o=1, nothing forwarded, err_o=1 the next cycle.
- PKT: ready_o = eng_ready_i[in_sel]. eng_val_o[in_sel] = val_i. An sop inside a packet is forwarded unchanged. On eop transfer, in_sel <= (in_sel==ENGINE_CNT-1) ? 0 : in_sel+1, and the FSM goes to IDLE.
- in_sel never skips a busy engine. If the selected engine is not ready, the stream waits.
- eng_data_o, eng_sop_o and eng_eop_o equal data_i, sop_i and eop_i at all times.
- Output side: when the FIFO is empty, val_o=0 and eng_ready_o=0. Otherwise out_sel = FIFO head, val_o = eng_val_i[out_sel], data/sop/eop are muxed from out_sel, and eng_ready_o[out_sel] = ready_i. Other engines see ready 0.
- Pop the FIFO on an output transfer with eop=1.
- FIFO full/empty come from registered counts, with no bypass. A push lands in the FIFO at the clock edge and is visible on the output side the next cycle. Simultaneous push and pop leave the count unchanged. Full blocks only a new sop; a pop in the same cycle does not unblock it.
- order_cnt_o = FIFO occupancy (0..ORDER_DEPTH).

Test Plan:
- Reset then 4 packets of 3 words, engines always ready, ready_i=1 -> eng_val_o targets engines 0,1,0,1. Output carries packets in input order. order_cnt_o peaks at 2 or more and ends at 0.
- Engine 1 returns its result before engine 0 (engine 0 result delayed 20 cycles) -> val_o stays 0 until engine 0's packet arrives. Engine 1 output is held via eng_ready_o[1]=0. Order is preserved.
- ORDER_DEPTH=4, ready_i=0, 5 packets offered -> 4 accepted, order_cnt_o=4, ready_o=0 on the 5th sop. Raising ready_i drains one packet, then the 5th is accepted.
- Single-beat packet (sop=eop=1, data 0x5) followed by a 2-beat packet -> the first goes to engine 0 and the second to engine 1. in_sel wraps to 0 after ENGINE_CNT packets.
- Stray beat (val=1, sop=0) while in IDLE -> ready_o=1, eng_val_o=0, err_o=1 for exactly one cycle. Next packet is unaffected.
- Assert rst_i mid-packet in PKT -> outputs drop immediately (val_o=0, order_cnt_o=0). The first sop after release goes to engine 0.
